instr_loader: RTL and testbench

- Write-side companion to the instruction ROM.
- Receives a program image as a byte stream over a valid/ready handshake and assembles 9-bit instructions. Writes each instruction into the 2^16 x 9 instruction memory at sequential 16-bit addresses.
- Holds the CPU in stall for the whole load. Raises done when the image has been written, or err if the image is malformed.

---
 rtl/instr_loader.sv | 144 ++++++++++++++
 tb/tb_instr_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: write-side companion to the instruction ROM.
// Receives a little-endian program image over a byte valid/ready stream.
// The image is a 16-bit instruction count followed by two bytes per instruction.
// Each 9-bit instruction is written to sequential addresses starting at BASE_ADDR.
// The CPU is held in stall while a load is in progress.
module instr_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic        wr_en_out,
    output logic [15:0] wr_addr_out,
    output logic [8:0]  wr_data_out,
    output logic        cpu_hold_out,
    output logic        done_out,
    output logic        err_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_INSTR_LO,
        S_INSTR_HI,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [7:0]  lo_byte;
    logic        xfer;
    logic        can_start;

    assign xfer      = byte_valid_in && byte_ready_out;
    assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    // done/err are sticky simply because DONE and ERR are held until a restart.
    always_comb begin
        state_nxt      = state;
        byte_ready_out = 1'b0;
        wr_en_out      = 1'b0;
        cpu_hold_out   = 1'b0;
        done_out       = 1'b0;
        err_out        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_in) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready_out = 1'b1;
                cpu_hold_out   = 1'b1;
                if (byte_valid_in) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready_out = 1'b1;
                cpu_hold_out   = 1'b1;
                if (byte_valid_in) begin
                    if ({byte_in, len[7:0]} == 16'd0) state_nxt = S_DONE;
                    else                              state_nxt = S_INSTR_LO;
                end
            end
            S_INSTR_LO: begin
                byte_ready_out = 1'b1;
                cpu_hold_out   = 1'b1;
                if (byte_valid_in) state_nxt = S_INSTR_HI;
            end
            S_INSTR_HI: begin
                byte_ready_out = 1'b1;
                cpu_hold_out   = 1'b1;
                if (byte_valid_in) begin
                    if (byte_in[7:1] != 7'd0) state_nxt = S_ERR;
                    else                      state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en_out    = 1'b1;
                cpu_hold_out = 1'b1;
                if (cnt == len - 16'd1) state_nxt = S_DONE;
                else                    state_nxt = S_INSTR_LO;
            end
            S_DONE: begin
                done_out = 1'b1;
                if (start_in) state_nxt = S_LEN_LO;
            end
            S_ERR: begin
                err_out = 1'b1;
                if (start_in) state_nxt = S_LEN_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: length, counter, low-byte holding and registered write port.
    // Address and data are captured on the INSTR_HI transfer so they are
    // already registered when WRITE drives the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len         <= '0;
            cnt         <= '0;
            lo_byte     <= '0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            if (can_start && start_in) begin
                cnt <= '0;
            end
            if (xfer && (state == S_LEN_LO)) begin
                len[7:0] <= byte_in;
            end
            if (xfer && (state == S_LEN_HI)) begin
                len[15:8] <= byte_in;
            end
            if (xfer && (state == S_INSTR_LO)) begin
                lo_byte <= byte_in;
            end
            if (xfer && (state == S_INSTR_HI) && (byte_in[7:1] == 7'd0)) begin
                wr_addr_out <= BASE_ADDR + cnt;
                wr_data_out <= {byte_in[0], lo_byte};
            end
            if (state == S_WRITE) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: two instances (BASE_ADDR 0 and FFFF) share the
// byte stream; a scoreboard queue holds the expected writes.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        valid = 1'b0;
    logic        sel = 1'b0;

    logic        rdy0, we0, hold0, done0, err0;
    logic [15:0] wa0;
    logic [8:0]  wd0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [15:0] wa1;
    logic [8:0]  wd1;
    logic        cur_rdy, cur_hold;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          dut;
        logic [15:0] addr;
        logic [8:0]  data;
    } exp_t;
    exp_t q[$];

    logic [7:0] img[16];
    int         img_n;

    instr_loader #(.BASE_ADDR(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_in(start0), .byte_in(byte_in),
        .byte_valid_in(valid), .byte_ready_out(rdy0), .wr_en_out(we0),
        .wr_addr_out(wa0), .wr_data_out(wd0), .cpu_hold_out(hold0),
        .done_out(done0), .err_out(err0)
    );

    instr_loader #(.BASE_ADDR(16'hFFFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_in(start1), .byte_in(byte_in),
        .byte_valid_in(valid), .byte_ready_out(rdy1), .wr_en_out(we1),
        .wr_addr_out(wa1), .wr_data_out(wd1), .cpu_hold_out(hold1),
        .done_out(done1), .err_out(err1)
    );

    assign cur_rdy  = sel ? rdy1 : rdy0;
    assign cur_hold = sel ? hold1 : hold0;

    always #5 clk = ~clk;

    // Scoreboard monitor: every write strobe from either instance pops one entry.
    always @(negedge clk) begin
        logic        we, rdy;
        logic [15:0] wa;
        logic [8:0]  wd;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            we  = (d == 1) ? we1 : we0;
            rdy = (d == 1) ? rdy1 : rdy0;
            wa  = (d == 1) ? wa1 : wa0;
            wd  = (d == 1) ? wd1 : wd0;
            if (we === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write dut%0d got addr=%h data=%h, required no write", d, wa, wd);
                end else begin
                    e = q.pop_front();
                    if (e.dut != d || wa !== e.addr || wd !== e.data) begin
                        fails++;
                        $display("FAIL write dut%0d got addr=%h data=%h, required dut%0d addr=%h data=%h",
                                 d, wa, wd, e.dut, e.addr, e.data);
                    end
                end
                tests++;
                if (rdy !== 1'b0) begin
                    fails++;
                    $display("FAIL ready_in_write dut%0d got %b, required 0", d, rdy);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running, required finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic expect_write(input int d, input logic [15:0] a, input logic [8:0] v);
        exp_t e;
        e.dut = d; e.addr = a; e.data = v;
        q.push_back(e);
    endtask

    task automatic start_load(input logic which);
        sel = which;
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        tests++;
        if (cur_hold !== 1'b1) begin
            fails++;
            $display("FAIL hold_after_start got %b, required 1", cur_hold);
        end
    endtask

    // Presents one byte after 'gap' idle cycles; returns #1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        repeat (gap) begin
            @(negedge clk);
            valid = 1'b0;
        end
        @(negedge clk);
        byte_in = b;
        valid   = 1'b1;
        budget  = 0;
        while (cur_rdy !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        tests++;
        if (budget >= 100) begin
            fails++;
            $display("FAIL byte_timeout byte=%h got ready=%b, required 1", b, cur_rdy);
            valid = 1'b0;
        end else begin
            if (cur_hold !== 1'b1) begin
                fails++;
                $display("FAIL hold_during_load got %b, required 1", cur_hold);
            end
            @(posedge clk);
            #1;
            valid = 1'b0;
        end
    endtask

    task automatic send_image(input int gapped);
        for (int i = 0; i < img_n; i++) begin
            send_byte(img[i], (gapped != 0 && (i % 2) == 1) ? 2 : 0);
        end
    endtask

    task automatic check_end(input string name, input logic exp_we, input logic exp_hold,
                             input logic exp_done, input logic exp_err);
        logic w, h, dn, er;
        w  = sel ? we1 : we0;
        h  = sel ? hold1 : hold0;
        dn = sel ? done1 : done0;
        er = sel ? err1 : err0;
        tests++;
        if (w !== exp_we || h !== exp_hold || dn !== exp_done || er !== exp_err) begin
            fails++;
            $display("FAIL %s got we=%b hold=%b done=%b err=%b, required we=%b hold=%b done=%b err=%b",
                     name, w, h, dn, er, exp_we, exp_hold, exp_done, exp_err);
        end
    endtask

    task automatic check_queue_empty(input string name);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s pending writes got %0d, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({rdy0, we0, wa0, wd0, hold0, done0, err0} !== '0 ||
            {rdy1, we1, wa1, wd1, hold1, done1, err1} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got nonzero output, required all 0");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_in = 8'($urandom_range(0, 255));
            valid   = 1'b1;
            tests++;
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || hold0 !== 1'b0 || hold1 !== 1'b0) begin
                fails++;
                $display("FAIL idle_no_accept got rdy0=%b rdy1=%b hold0=%b hold1=%b, required 0",
                         rdy0, rdy1, hold0, hold1);
            end
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic load_basic_image;
        img = '{8'h03, 8'h00, 8'h2A, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        img_n = 8;
        expect_write(0, 16'h0000, 9'h02A);
        expect_write(0, 16'h0001, 9'h1FF);
        expect_write(0, 16'h0002, 9'h100);
    endtask

    task automatic test_basic;
        start_load(1'b0);
        load_basic_image();
        send_image(0);
        check_end("basic_write_cycle", 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_end("basic_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check_queue_empty("basic");
    endtask

    task automatic test_backpressure;
        start_load(1'b0);
        tests++;
        if (done0 !== 1'b0) begin
            fails++;
            $display("FAIL restart_clears_done got %b, required 0", done0);
        end
        load_basic_image();
        send_image(1);
        check_end("gap_write_cycle", 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_end("gap_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check_queue_empty("gap");
    endtask

    task automatic test_zero_and_wrap;
        start_load(1'b1);
        img[0] = 8'h00; img[1] = 8'h00;
        img_n = 2;
        send_image(0);
        check_end("zero_len_done", 1'b0, 1'b0, 1'b1, 1'b0);
        start_load(1'b1);
        img[0] = 8'h02; img[1] = 8'h00; img[2] = 8'h11; img[3] = 8'h00;
        img[4] = 8'h22; img[5] = 8'h00;
        img_n = 6;
        expect_write(1, 16'hFFFF, 9'h011);
        expect_write(1, 16'h0000, 9'h022);
        send_image(0);
        @(posedge clk);
        #1;
        check_end("wrap_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check_queue_empty("wrap");
        sel = 1'b0;
    endtask

    task automatic test_error;
        start_load(1'b0);
        img[0] = 8'h02; img[1] = 8'h00; img[2] = 8'h05; img[3] = 8'h00;
        img[4] = 8'h07; img[5] = 8'h02;
        img_n = 6;
        expect_write(0, 16'h0000, 9'h005);
        send_image(0);
        check_end("err_state", 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_end("err_sticky", 1'b0, 1'b0, 1'b0, 1'b1);
        check_queue_empty("err");
        start_load(1'b0);
        check_end("err_cleared", 1'b0, 1'b1, 1'b0, 1'b0);
        img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h33; img[3] = 8'h00;
        img_n = 4;
        expect_write(0, 16'h0000, 9'h033);
        send_image(0);
        @(posedge clk);
        #1;
        check_end("err_restart_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check_queue_empty("err_restart");
    endtask

    task automatic test_reset_mid_load;
        start_load(1'b0);
        img[0] = 8'h04; img[1] = 8'h00; img[2] = 8'h01; img[3] = 8'h00;
        img[4] = 8'h02;
        img_n = 5;
        expect_write(0, 16'h0000, 9'h001);
        send_image(0);
        @(negedge clk);
        byte_in = 8'h00;
        valid   = 1'b1;
        tests++;
        if (rdy0 !== 1'b1) begin
            fails++;
            $display("FAIL in_instr_hi got ready=%b, required 1", rdy0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rdy0, we0, wa0, wd0, hold0, done0, err0} !== '0) begin
            fails++;
            $display("FAIL midload_reset got rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
                     rdy0, we0, wa0, wd0, hold0, done0, err0);
        end
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_queue_empty("midload_reset");
        start_load(1'b0);
        img[0] = 8'h02; img[1] = 8'h00; img[2] = 8'h44; img[3] = 8'h00;
        img[4] = 8'h55; img[5] = 8'h01;
        img_n = 6;
        expect_write(0, 16'h0000, 9'h044);
        expect_write(0, 16'h0001, 9'h155);
        send_image(0);
        @(posedge clk);
        #1;
        check_end("reload_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check_queue_empty("reload");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_wrap();
        test_error();
        test_reset_mid_load();
        repeat (5) @(negedge clk);
        check_queue_empty("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
